// File: rtl/regs_pkg.sv
// Shared FSM state type, allowed register counts and the parity helper for regs_mp.
package regs_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } regs_state_e;

    localparam int REGS_RV32I = 32;
    localparam int REGS_RV32E = 16;

    // Even parity over a zero-extended word; callers widen their data to 64 bits.
    function automatic logic calc_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/regs_rd_port.sv
// One read port of regs_mp: gating, write forwarding, optional output register
// and, when REGS_PARITY_EN is defined, the parity check of the stored word.
module regs_rd_port
    import regs_pkg::*;
#(
    parameter int    XLEN     = 32,
    parameter int    AW       = 5,
    parameter int    SW       = 32,
    parameter string REG_OUTS = "TRUE",
    parameter string BYPASS   = "TRUE"
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   rsa_i,
    input  logic            rsr_i,
    input  logic            busy_i,
    input  logic [SW-1:0]   rd_word_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] rs_o,
    output logic            par_err_o
);

    logic            gate_on;
    logic            fwd_hit;
    logic            arr_perr;
    logic [XLEN-1:0] arr_data;

    assign gate_on  = rsr_i && (rsa_i != '0) && !busy_i;
    assign fwd_hit  = wr_en_i && (wr_addr_i == rsa_i);
    assign arr_data = rd_word_i[XLEN-1:0];

`ifdef REGS_PARITY_EN
    assign arr_perr = (calc_parity(64'(arr_data)) != rd_word_i[XLEN]);
`else
    assign arr_perr = 1'b0;
`endif

    if (REG_OUTS == "TRUE") begin : g_reg
        logic [XLEN-1:0] rs_q, rs_d;
        logic            perr_q, perr_d;

        // Write-first capture; forwarded data bypasses storage so it never flags parity.
        always_comb begin
            rs_d   = '0;
            perr_d = 1'b0;
            if (gate_on) begin
                rs_d   = fwd_hit ? wr_data_i : arr_data;
                perr_d = !fwd_hit && arr_perr;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rs_q   <= '0;
                perr_q <= 1'b0;
            end else begin
                rs_q   <= rs_d;
                perr_q <= perr_d;
            end
        end

        assign rs_o      = rs_q;
        assign par_err_o = perr_q;
    end else begin : g_comb
        logic use_fwd;
        logic unused_clk;

        assign use_fwd    = (BYPASS == "TRUE") && fwd_hit;
        assign unused_clk = clk_i ^ rst_i;

        always_comb begin
            rs_o      = '0;
            par_err_o = 1'b0;
            if (gate_on) begin
                rs_o      = use_fwd ? wr_data_i : arr_data;
                par_err_o = !use_fwd && arr_perr;
            end
        end
    end

endmodule

// File: rtl/regs_mp.sv
// Parametrised integer register file with a hardware clear sequencer after reset.
// Define REGS_PARITY_EN to store an even-parity bit per entry and flag read errors.
module regs_mp
    import regs_pkg::*;
#(
    parameter int    XLEN     = 32,
    parameter int    REG_CNT  = REGS_RV32I,
    parameter int    RD_PORTS = 2,
    parameter string REG_OUTS = "TRUE",
    parameter string BYPASS   = "TRUE",
    localparam int   AW       = $clog2(REG_CNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RD_PORTS*AW-1:0]   rsa,
    input  logic [RD_PORTS-1:0]      rsr,
    output logic [RD_PORTS*XLEN-1:0] rs,
    input  logic [AW-1:0]            rda,
    input  logic [XLEN-1:0]          rd,
    input  logic                     rdw,
    output logic                     busy,
    output logic [RD_PORTS-1:0]      par_err
);

`ifdef REGS_PARITY_EN
    localparam int SW = XLEN + 1;
`else
    localparam int SW = XLEN;
`endif

    if (REG_CNT != REGS_RV32I && REG_CNT != REGS_RV32E) begin : g_bad_reg_cnt
        $error("regs_mp: REG_CNT must be 16 or 32");
    end
    if (XLEN < 8 || XLEN > 64) begin : g_bad_xlen
        $error("regs_mp: XLEN must be within 8..64");
    end
    if (RD_PORTS < 1 || RD_PORTS > 4) begin : g_bad_ports
        $error("regs_mp: RD_PORTS must be within 1..4");
    end

    regs_state_e   state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          wr_en;
    logic [SW-1:0] wr_word;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [SW-1:0] mem_wdata;
    logic [SW-1:0] mem_q [REG_CNT];

    assign busy  = (state_q == ST_CLEAR);
    assign wr_en = (state_q == ST_RUN) && rdw && (rda != '0);

`ifdef REGS_PARITY_EN
    assign wr_word = {calc_parity(64'(rd)), rd};
`else
    assign wr_word = rd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // The clear sequence owns the single write port until the last entry is zeroed.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(REG_CNT - 1)) begin
                    state_d   = ST_RUN;
                    clr_idx_d = '0;
                end
            end
            ST_RUN: begin
                if (wr_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = rda;
                    mem_wdata = wr_word;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // No reset on the array so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_port
        regs_rd_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .SW       (SW),
            .REG_OUTS (REG_OUTS),
            .BYPASS   (BYPASS)
        ) u_port (
            .clk_i     (clk),
            .rst_i     (rst),
            .rsa_i     (rsa[i*AW +: AW]),
            .rsr_i     (rsr[i]),
            .busy_i    (busy),
            .rd_word_i (mem_q[rsa[i*AW +: AW]]),
            .wr_en_i   (wr_en),
            .wr_addr_i (rda),
            .wr_data_i (rd),
            .rs_o      (rs[i*XLEN +: XLEN]),
            .par_err_o (par_err[i])
        );
    end

endmodule

// File: tb/tb_regs_mp.sv
// Scoreboard bench for regs_mp: one registered instance and two combinational ones
// (with and without bypass) share stimulus and are checked against a register-array model.
`timescale 1ns/1ps
module tb_regs_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NP   = 2;
    localparam int AW   = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [NP*AW-1:0]   rsa;
    logic [NP-1:0]      rsr;
    logic [AW-1:0]      rda;
    logic [XLEN-1:0]    rd;
    logic               rdw;
    logic [NP*XLEN-1:0] rsR, rsN, rsB;
    logic               busyR, busyN, busyB;
    logic [NP-1:0]      peR, peN, peB;

    always #5 clk = ~clk;

    regs_mp #(.XLEN(XLEN), .REG_CNT(NREG), .RD_PORTS(NP), .REG_OUTS("TRUE"), .BYPASS("TRUE")) dutR (
        .clk(clk), .rst(rst), .rsa(rsa), .rsr(rsr), .rs(rsR), .rda(rda), .rd(rd), .rdw(rdw),
        .busy(busyR), .par_err(peR));
    regs_mp #(.XLEN(XLEN), .REG_CNT(NREG), .RD_PORTS(NP), .REG_OUTS("FALSE"), .BYPASS("FALSE")) dutN (
        .clk(clk), .rst(rst), .rsa(rsa), .rsr(rsr), .rs(rsN), .rda(rda), .rd(rd), .rdw(rdw),
        .busy(busyN), .par_err(peN));
    regs_mp #(.XLEN(XLEN), .REG_CNT(NREG), .RD_PORTS(NP), .REG_OUTS("FALSE"), .BYPASS("TRUE")) dutB (
        .clk(clk), .rst(rst), .rsa(rsa), .rsr(rsr), .rs(rsB), .rda(rda), .rd(rd), .rdw(rdw),
        .busy(busyB), .par_err(peB));

    typedef struct {
        string                   tag;
        logic                    busy;
        logic [NP-1:0][XLEN-1:0] regRs;
        logic [NP-1:0]           regPe;
        logic [NP-1:0][XLEN-1:0] nbRs;
        logic [NP-1:0]           nbPe;
        logic [NP-1:0][XLEN-1:0] bpRs;
        logic [NP-1:0]           bpPe;
    } expect_t;

    expect_t                 expQ[$];
    logic [XLEN-1:0]         modelRegs [NREG];
    bit                      corrupt [NREG];
    int                      clearLeft;
    logic [NP-1:0][XLEN-1:0] pendRs;
    logic [NP-1:0]           pendPe;
    int                      errors = 0;
    int                      checks = 0;

    task automatic checkVal(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        checkVal({e.tag, " busyR"}, XLEN'(busyR), XLEN'(e.busy));
        checkVal({e.tag, " busyN"}, XLEN'(busyN), XLEN'(e.busy));
        checkVal({e.tag, " busyB"}, XLEN'(busyB), XLEN'(e.busy));
        for (int p = 0; p < NP; p++) begin
            checkVal($sformatf("%s rsReg[%0d]", e.tag, p), rsR[p*XLEN +: XLEN], e.regRs[p]);
            checkVal($sformatf("%s rsNoByp[%0d]", e.tag, p), rsN[p*XLEN +: XLEN], e.nbRs[p]);
            checkVal($sformatf("%s rsByp[%0d]", e.tag, p), rsB[p*XLEN +: XLEN], e.bpRs[p]);
            checkVal($sformatf("%s parReg[%0d]", e.tag, p), XLEN'(peR[p]), XLEN'(e.regPe[p]));
            checkVal($sformatf("%s parNoByp[%0d]", e.tag, p), XLEN'(peN[p]), XLEN'(e.nbPe[p]));
            checkVal($sformatf("%s parByp[%0d]", e.tag, p), XLEN'(peB[p]), XLEN'(e.bpPe[p]));
        end
    endtask

    // Drives one clock cycle of inputs, predicts every output and advances the model by one edge.
    task automatic applyStimulus(input string tag, input logic rstIn,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [NP-1:0] en, input logic wr,
                                 input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
        expect_t       e;
        logic [AW-1:0] a;
        logic          on, hit;
        @(negedge clk);
        rst = rstIn;
        rsa = {a1, a0};
        rsr = en;
        rdw = wr;
        rda = wa;
        rd  = wd;
        e.tag  = tag;
        e.busy = rstIn || (clearLeft > 0);
        for (int p = 0; p < NP; p++) begin
            a   = (p == 0) ? a0 : a1;
            on  = en[p] && (a != 0) && !e.busy;
            hit = wr && (wa == a);
            e.nbRs[p]  = on ? modelRegs[a] : '0;
            e.nbPe[p]  = on && corrupt[a];
            e.bpRs[p]  = on ? (hit ? wd : modelRegs[a]) : '0;
            e.bpPe[p]  = on && !hit && corrupt[a];
            e.regRs[p] = rstIn ? '0 : pendRs[p];
            e.regPe[p] = rstIn ? 1'b0 : pendPe[p];
            pendRs[p]  = rstIn ? '0 : e.bpRs[p];
            pendPe[p]  = rstIn ? 1'b0 : e.bpPe[p];
        end
        if (rstIn) begin
            clearLeft = NREG;
            for (int i = 0; i < NREG; i++) begin
                modelRegs[i] = '0;
                corrupt[i]   = 1'b0;
            end
        end else if (clearLeft > 0) begin
            clearLeft--;
        end else if (wr && wa != 0) begin
            modelRegs[wa] = wd;
            corrupt[wa]   = 1'b0;
        end
        expQ.push_back(e);
    endtask

    task automatic randomCycle(input string tag, input logic wrAllowed);
        logic [AW-1:0] a0, a1, wa;
        a0 = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
        a1 = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
        wa = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
        applyStimulus(tag, 1'b0, a0, a1, NP'($urandom_range(0, 3)),
                      wrAllowed && 1'($urandom_range(0, 1)), wa, XLEN'($urandom));
    endtask

    // Monitor: samples just before each rising edge and retires one expectation per cycle.
    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk);
            #4;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        rst = 1'b1;
        rsa = '0;
        rsr = '0;
        rda = '0;
        rd  = '0;
        rdw = 1'b0;
        clearLeft = NREG;
        pendRs = '0;
        pendPe = '0;
        for (int i = 0; i < NREG; i++) begin
            modelRegs[i] = '0;
            corrupt[i]   = 1'b0;
        end

        repeat (3) applyStimulus("reset", 1'b1, 0, 0, 2'b11, 1'b0, 0, 0);
        for (int i = 0; i < NREG; i++) applyStimulus("clear_wr_x5", 1'b0, 5, 5, 2'b11, 1'b1, 5, 32'h1234);
        applyStimulus("rd_x5_after_clear", 1'b0, 5, 5, 2'b11, 1'b0, 0, 0);
        applyStimulus("rd_x5_after_clear2", 1'b0, 5, 5, 2'b11, 1'b0, 0, 0);

        applyStimulus("wr_rd_x7", 1'b0, 7, 7, 2'b11, 1'b1, 7, 32'hDEADBEEF);
        applyStimulus("rd_x7", 1'b0, 7, 7, 2'b11, 1'b0, 0, 0);

        applyStimulus("wr_x0", 1'b0, 0, 0, 2'b11, 1'b1, 0, 32'hFFFFFFFF);
        applyStimulus("wr_x3_rd_x0", 1'b0, 0, 0, 2'b11, 1'b1, 3, 32'hA5A5A5A5);
        applyStimulus("rd_x3_disabled", 1'b0, 3, 3, 2'b00, 1'b0, 0, 0);
        applyStimulus("rd_x3_enabled", 1'b0, 3, 3, 2'b11, 1'b0, 0, 0);

        applyStimulus("wr_rd_x9", 1'b0, 9, 9, 2'b11, 1'b1, 9, 32'h55);
        applyStimulus("rd_x9", 1'b0, 9, 9, 2'b11, 1'b0, 0, 0);

        for (int i = 0; i < 400; i++) randomCycle("random", 1'b1);

        repeat (3) applyStimulus("rst_in_run", 1'b1, 3, 7, 2'b11, 1'b1, 4, 32'hCAFE);
        for (int i = 0; i < 10; i++) randomCycle("clear_part", 1'b1);
        repeat (3) applyStimulus("rst_mid_clear", 1'b1, 3, 7, 2'b11, 1'b1, 6, 32'hBEEF);
        for (int i = 0; i < NREG; i++) randomCycle("clear_again", 1'b1);
        for (int i = 0; i < NREG / 2; i++)
            applyStimulus("rd_all_zero", 1'b0, AW'(2 * i), AW'(2 * i + 1), 2'b11, 1'b0, 0, 0);

`ifdef REGS_PARITY_EN
        applyStimulus("par_wr_x4", 1'b0, 0, 0, 2'b00, 1'b1, 4, 32'h1);
        @(posedge clk);
        #1;
        dutR.mem_q[4][0] = ~dutR.mem_q[4][0];
        dutN.mem_q[4][0] = ~dutN.mem_q[4][0];
        dutB.mem_q[4][0] = ~dutB.mem_q[4][0];
        modelRegs[4] = modelRegs[4] ^ 32'h1;
        corrupt[4]   = 1'b1;
        applyStimulus("par_rd_bad_x4", 1'b0, 4, 0, 2'b01, 1'b0, 0, 0);
        applyStimulus("par_rd_bad_x4b", 1'b0, 4, 4, 2'b11, 1'b0, 0, 0);
        applyStimulus("par_rewrite_x4", 1'b0, 4, 0, 2'b01, 1'b1, 4, 32'h1);
        applyStimulus("par_rd_clean_x4", 1'b0, 4, 4, 2'b11, 1'b0, 0, 0);
`endif

        for (int i = 0; i < 20; i++) randomCycle("tail", 1'b1);
        applyStimulus("drain", 1'b0, 0, 0, 2'b00, 1'b0, 0, 0);

        #6;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regs_mp.md
Name: regs_mp

Overview:
- Parametrised successor of the core's integer register file.
- Configurable data width, register count (RV32I/RV32E) and number of read ports, plus a selectable registered or combinational read path.
- Adds a hardware clear sequencer that zeroes the array after reset and reports `busy`. This removes the need for initial blocks, so the block can map to distributed RAM on any platform.
- Sits between decode (read addresses) and writeback (write port), like the existing file.

Parameters:
- XLEN, 32, data width in bits (8..64).
- REG_CNT, 32, number of registers; 16 or 32 only; any other value is an elaboration error.
- RD_PORTS, 2, number of read ports (1..4).
- REG_OUTS, "TRUE", "TRUE" = registered read (latency 1); "FALSE" = combinational read.
- BYPASS, "TRUE", combinational mode only: forward the same-cycle write to reads.

Ports (AW = clog2(REG_CNT)):
- clk  in  1  core clock.
- rst  in  1  **asynchronous, active-high reset.**
- rsa  in  RD_PORTS*AW  read addresses, port i at [i*AW +: AW].
- rsr  in  RD_PORTS  read enables.
- rs  out  RD_PORTS*XLEN  read data, port i at [i*XLEN +: XLEN].
- rda  in  AW  write address.
- rd  in  XLEN  write data.
- rdw  in  1  write enable.
- busy  out  1  clear sequence in progress.
- par_err  out  RD_PORTS  parity error per read port (driven 0 unless REGS_PARITY_EN).

Behaviour:
- One clock domain: clk. Reset `rst` is asynchronous and active-high.
- FSM states: CLEAR, RUN.
  - `rst` high forces CLEAR, clr_idx=0, busy=1, all registered rs=0, par_err=0.
  - In CLEAR, each clk with rst low writes 0 to REG[clr_idx] and increments clr_idx.
  - When clr_idx==REG_CNT-1 is written, next state is RUN and busy=0.
  - busy therefore stays high for exactly REG_CNT cycles after reset release.
- Reset asserted mid-CLEAR or mid-RUN: the sequence restarts at index 0. A write in flight at that edge is discarded.
- While busy:
  - rdw is ignored.
  - Every rs port reads 0; registered mode captures 0.
- RUN write:
  - On a clk edge with rdw=1 and rda!=0, REG[rda] <= rd.
  - Writes to address 0 are discarded; x0 stays zero.
- Read gating, per port i: when rsr[i]=0 or rsa_i==0, rs_i=0.
- REG_OUTS="TRUE":
  - At each edge, rs_i <= (rdw && rda==rsa_i) ? rd : REG[rsa_i]. Write-first forwarding, subject to the gating above.
  - Latency 1 cycle; reset value 0.
  - Every port forwards independently; all ports may read the same address.
- REG_OUTS="FALSE":
  - rs_i = REG[rsa_i], subject to gating.
  - With BYPASS="TRUE", if rdw && rda==rsa_i the value is rd combinationally.
  - With BYPASS="FALSE", the written value becomes visible the cycle after the write.
- No read/write port contention: there is one write port, and any number of reads are allowed per cycle.

Optional Feature:
- Macro: REGS_PARITY_EN.
- Defined:
  - Each entry stores XLEN+1 bits. The extra bit is even parity (XOR of the data), computed on write. The clear sequence writes parity 0.
  - Every gated-on read recomputes parity. On mismatch, par_err[i]=1, with timing aligned to rs_i (registered or combinational per REG_OUTS).
  - Forwarded data never flags.
  - The data output is unchanged, with no correction.
- Undefined: storage is XLEN bits wide and par_err is tied to 0.

Decomposition:
- Package regs_pkg holds:
  - the FSM state enum (ST_CLEAR, ST_RUN);
  - the allowed REG_CNT constants (REGS_RV32I=32, REGS_RV32E=16);
  - the parity function.
- Sub-module regs_rd_port holds one read port: gating, forwarding, the output register and the parity check. It is instantiated RD_PORTS times in a generate loop; the top keeps the array, the FSM and the write path.

Test Plan:
- Reset release, REG_CNT=32: busy is high for exactly 32 cycles. rdw=1, rda=5, rd=0x1234 during busy is dropped, so a read of x5 after busy=0 returns 0x00000000.
- RUN, REG_OUTS="TRUE": write x7=0xDEADBEEF and read x7 on both ports in the same cycle; both rs ports show 0xDEADBEEF on the next cycle.
- Write x0=0xFFFFFFFF, then read x0 with rsr=1 → 0; read x3 (holding 0xA5A5A5A5) with rsr=0 → 0.
- REG_OUTS="FALSE", BYPASS="FALSE": write x9=0x55 → same-cycle read is 0, next-cycle read is 0x55. With BYPASS="TRUE" the same-cycle read is 0x55.
- Assert rst at clear index 10, hold 3 cycles, release: busy is high for a further 32 cycles and every register reads 0 afterwards.
- REGS_PARITY_EN: write x4=0x1, force-flip the stored bit 0, then read x4 → rs=0x0 and par_err[0]=1 in the same cycle as rs. A clean read of x4 afterwards with a fresh write → par_err=0.
